wb_arbiter_rr2: RTL and testbench



---
 rtl/wb_arbiter_rr2.sv | 188 ++++++++++++++++++
 tb/tb_wb_arbiter_rr2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr2.sv
// Two-master round-robin arbiter for a pipelined Wishbone slave with a bus-timeout watchdog.
// The grant is registered state only; forwarding and responses are combinational from that state.
module wb_arbiter_rr2 #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned SEL_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_stall_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    ABORT = 2'd3
  } state_e;

  localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               own_cyc;
  logic               other_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Cyc of the master currently holding the bus, and of the one waiting.
  always_comb begin
    own_cyc   = 1'b0;
    other_cyc = 1'b0;
    if (state_q == BUSY0) begin
      own_cyc   = m0_cyc_i;
      other_cyc = m1_cyc_i;
    end else if (state_q == BUSY1) begin
      own_cyc   = m1_cyc_i;
      other_cyc = m0_cyc_i;
    end
  end

  // last_grant always names the master that owns (or last owned) the bus,
  // so in ABORT it also identifies the offender.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_grant_q) begin
            state_d      = BUSY0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = BUSY1;
            last_grant_d = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d      = BUSY0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = BUSY1;
          last_grant_d = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        if (!own_cyc) begin
          tmo_cnt_d = '0;
          if (other_cyc) begin
            state_d      = (state_q == BUSY0) ? BUSY1 : BUSY0;
            last_grant_d = (state_q == BUSY0);
          end else begin
            state_d = IDLE;
          end
        end else if (s_ack_i) begin
          tmo_cnt_d = '0;
        end else if (WDOG_EN && (tmo_cnt_q == TMO_LAST)) begin
          state_d   = ABORT;
          tmo_cnt_d = '0;
        end else if (WDOG_EN) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ABORT: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    unique case (state_q)
      BUSY0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_stall_o = s_stall_i;
        m0_ack_o   = s_ack_i;
      end
      BUSY1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_stall_o = s_stall_i;
        m1_ack_o   = s_ack_i;
      end
      ABORT: begin
        m0_err_o = ~last_grant_q;
        m1_err_o = last_grant_q;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Directed bench for wb_arbiter_rr2 with an 8-cycle watchdog; the slave side is driven by hand.
module tb_wb_arbiter_rr2;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;

  logic        clk;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_stall_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_stall_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_stall_i;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int acc_base;

  wb_arbiter_rr2 #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_stall_i(s_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writes accepted by the slave (stb seen while not stalled).
  always @(posedge clk)
    if (s_cyc_o && s_stb_o && s_we_o && !s_stall_i) n_acc <= n_acc + 1;

  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_stall_i = 0;
    step(); step();

    // Reset state
    check("rst_s_cyc", 32'(s_cyc_o), 0);
    check("rst_s_stb", 32'(s_stb_o), 0);
    check("rst_s_we", 32'(s_we_o), 0);
    check("rst_s_sel", 32'(s_sel_o), 0);
    check("rst_s_adr", s_adr_o, 0);
    check("rst_s_dat", s_dat_o, 0);
    check("rst_m0_ack", 32'(m0_ack_o), 0);
    check("rst_m0_err", 32'(m0_err_o), 0);
    check("rst_m0_stall", 32'(m0_stall_o), 1);
    check("rst_m1_ack", 32'(m1_ack_o), 0);
    check("rst_m1_err", 32'(m1_err_o), 0);
    check("rst_m1_stall", 32'(m1_stall_o), 1);
    rst = 1'b0;

    // Single master read
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hf; m0_adr_i = 32'h8000_0000;
    #1;
    check("sm_latency_cyc", 32'(s_cyc_o), 0);
    check("sm_latency_stall", 32'(m0_stall_o), 1);
    step();
    check("sm_s_cyc", 32'(s_cyc_o), 1);
    check("sm_s_stb", 32'(s_stb_o), 1);
    check("sm_s_adr", s_adr_o, 32'h8000_0000);
    check("sm_m0_stall", 32'(m0_stall_o), 0);
    check("sm_m1_stall", 32'(m1_stall_o), 1);
    check("sm_m0_ack_early", 32'(m0_ack_o), 0);
    m0_stb_i = 0;
    step();
    s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
    #1;
    check("sm_m0_ack", 32'(m0_ack_o), 1);
    check("sm_m0_dat", m0_dat_o, 32'hCAFE_F00D);
    check("sm_m1_ack", 32'(m1_ack_o), 0);
    check("sm_m1_stall_ack", 32'(m1_stall_o), 1);
    step();
    s_ack_i = 0; m0_cyc_i = 0;
    step();
    check("sm_idle_cyc", 32'(s_cyc_o), 0);

    // Tie after reset, then back-to-back handovers
    rst = 1; step(); rst = 0;
    m0_adr_i = A0; m1_adr_i = A1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("tie_g0_adr", s_adr_o, A0);
    check("tie_g0_m0_stall", 32'(m0_stall_o), 0);
    check("tie_g0_m1_stall", 32'(m1_stall_o), 1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    check("tie_g1_adr", s_adr_o, A1);
    check("tie_g1_cyc", 32'(s_cyc_o), 1);
    check("tie_g1_m1_stall", 32'(m1_stall_o), 0);
    check("tie_g1_m0_stall", 32'(m0_stall_o), 1);
    m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    step();
    check("tie_g2_adr", s_adr_o, A0);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("tie_g3_adr", s_adr_o, A1);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    check("tie_idle_cyc", 32'(s_cyc_o), 0);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("tie2_adr", s_adr_o, A0);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // Stall pass-through on an m1 write
    acc_base = n_acc;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011;
    m1_dat_i = 32'hDEAD_BEEF; m1_adr_i = 32'h0000_0100; s_stall_i = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("st_m1_stall", 32'(m1_stall_o), 1);
      check("st_s_sel", 32'(s_sel_o), 32'h3);
      check("st_s_dat", s_dat_o, 32'hDEAD_BEEF);
      check("st_s_we", 32'(s_we_o), 1);
      step();
    end
    s_stall_i = 0;
    #1;
    check("st_m1_unstall", 32'(m1_stall_o), 0);
    step();
    m1_stb_i = 0; s_ack_i = 1;
    #1;
    check("st_m1_ack", 32'(m1_ack_o), 1);
    check("st_m0_ack", 32'(m0_ack_o), 0);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_we_i = 0;
    step();
    check("st_accepts", 32'(n_acc - acc_base), 1);

    // Timeout with m1 pending
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = A0;
    step();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = A1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("to_no_err", 32'(m0_err_o), 0);
      check("to_s_cyc", 32'(s_cyc_o), 1);
      if (i == 0) m0_stb_i = 0;
      step();
    end
    check("to_m0_err", 32'(m0_err_o), 1);
    check("to_s_cyc_abort", 32'(s_cyc_o), 0);
    check("to_s_stb_abort", 32'(s_stb_o), 0);
    check("to_m0_stall", 32'(m0_stall_o), 1);
    check("to_m0_ack", 32'(m0_ack_o), 0);
    check("to_m1_err", 32'(m1_err_o), 0);
    m0_cyc_i = 0;
    step();
    check("to_err_one_cycle", 32'(m0_err_o), 0);
    check("to_idle_cyc", 32'(s_cyc_o), 0);
    step();
    check("to_m1_granted", 32'(m1_stall_o), 0);
    check("to_m1_adr", s_adr_o, A1);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // Ack on the timeout boundary cycle
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    for (int i = 0; i < 7; i++) begin
      check("bd_no_err", 32'(m0_err_o), 0);
      if (i == 0) m0_stb_i = 0;
      step();
    end
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    check("bd_ack", 32'(m0_ack_o), 1);
    check("bd_ack_err", 32'(m0_err_o), 0);
    check("bd_dat", m0_dat_o, 32'h1234_5678);
    step();
    s_ack_i = 0;
    #1;
    for (int i = 0; i < 7; i++) begin
      check("bd_cleared_err", 32'(m0_err_o), 0);
      check("bd_cleared_cyc", 32'(s_cyc_o), 1);
      step();
    end
    check("bd_last_err", 32'(m0_err_o), 0);
    check("bd_last_cyc", 32'(s_cyc_o), 1);
    m0_cyc_i = 0;
    step();
    check("bd_idle_err", 32'(m0_err_o), 0);

    // Reset mid-burst in BUSY1
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("rm_busy1_stb", 32'(s_stb_o), 1);
    rst = 1;
    step();
    rst = 0; s_ack_i = 1;
    #1;
    check("rm_s_cyc", 32'(s_cyc_o), 0);
    check("rm_s_stb", 32'(s_stb_o), 0);
    check("rm_m0_stall", 32'(m0_stall_o), 1);
    check("rm_m1_stall", 32'(m1_stall_o), 1);
    check("rm_m0_ack", 32'(m0_ack_o), 0);
    check("rm_m1_ack", 32'(m1_ack_o), 0);
    check("rm_m0_err", 32'(m0_err_o), 0);
    check("rm_m1_err", 32'(m1_err_o), 0);
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
    step();
    check("rm_tie_m0_stall", 32'(m0_stall_o), 0);
    check("rm_tie_m1_stall", 32'(m1_stall_o), 1);
    check("rm_tie_adr", s_adr_o, A0);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
